image_pair_streamer: RTL and testbench
======================================

Name: image_pair_streamer

Overview:
Synthesizable frame source that reads an RGB888 image, stored as pixel pairs, from a synchronous frame memory. It emits the image as a stream of even/odd pixel pairs framed by VSYNC/HSYNC timing. It sits directly upstream of the BMP writer / pixel-processing stages: its HSYNC and DATA_* outputs drive their hsync and DATA_WRITE_* inputs, in top-row-first, left-to-right order.

Parameters:
WIDTH, 768, image width in pixels; must be even, ≥4
HEIGHT, 512, image height in rows; ≥1
START_UP_DELAY, 100, cycles VSYNC is held high before the first row
HSYNC_DELAY, 160, blanking cycles before every row, including the first
ADDR_W, 18, memory address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT/2

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  pair address = row*(WIDTH/2)+col
mem_rdata  in  48  {R0,G0,B0,R1,G1,B1}, R0 at [47:40]; valid the cycle after mem_rd_en
VSYNC  out  1  high during start-up delay
HSYNC  out  1  qualifies DATA_* (one pixel pair per high cycle)
DATA_R0/G0/B0  out  8 each  even pixel (left of the pair)
DATA_R1/G1/B1  out  8 each  odd pixel (right of the pair)
busy  out  1  high from the cycle after start is accepted until ctrl_done inclusive
ctrl_done  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE; all counters 0; every output 0.
- FSM states: IDLE, VSYNC, HSYNC, DATA, DONE.
- IDLE: start=1 → VSYNC. Otherwise stay.
- VSYNC: VSYNC=1 for exactly START_UP_DELAY cycles, then → HSYNC.
- HSYNC: blanking for exactly HSYNC_DELAY cycles (mem_rd_en=0), then → DATA.
- DATA: exactly WIDTH/2 cycles, mem_rd_en=1 each cycle, col counter 0..WIDTH/2-1, mem_addr = row*(WIDTH/2)+col.
  - At the end of a row, col wraps to 0.
  - If row<HEIGHT-1: row increments, → HSYNC.
  - Else: → DONE.
- DONE: exactly 3 cycles, then → IDLE. ctrl_done=1 in the third DONE cycle only.
- Output pipeline, fixed 2-cycle latency:
  - mem_rd_en in cycle t produces mem_rdata in t+1.
  - That data is registered onto DATA_* with HSYNC=1 in cycle t+2.
  - HSYNC is mem_rd_en delayed by exactly 2 cycles.
- DATA_* hold their last value while HSYNC=0 (0 after reset).
- Last pair: last DATA cycle t → HSYNC high at t+2, ctrl_done at t+3, IDLE at t+4. ctrl_done never coincides with HSYNC.
- busy=1 in all non-IDLE states.
- start while busy: ignored, no restart, no queuing.
- start in the same cycle ctrl_done is high: ignored (FSM is still in DONE).
- HSYNC pulses per frame: exactly WIDTH*HEIGHT/2 (196608 at defaults); mem_addr never exceeds WIDTH*HEIGHT/2-1.
- Reset mid-frame: the frame is abandoned; no ctrl_done is issued. The next start begins a full frame from row 0, col 0 with the full START_UP_DELAY.
- Counter widths: delay counter sized for max(START_UP_DELAY, HSYNC_DELAY); row counter ≥ clog2(HEIGHT); col counter ≥ clog2(WIDTH/2).
- The address product is computed at ADDR_W bits with no truncation for legal parameters.

Test Plan (WIDTH=8, HEIGHT=4, START_UP_DELAY=4, HSYNC_DELAY=2, memory model returns {addr repeated} per pair; start pulsed in cycle 0):
- Basic frame: VSYNC high in cycles 1-4. Rows occupy cycles 5-10, 11-16, 17-22, 23-28, with mem_rd_en in the last 4 cycles of each. HSYNC high in cycles 9-12, 15-18, 21-24, 27-30. ctrl_done only in cycle 31. busy in cycles 1-31.
- Data ordering: the 16 HSYNC beats carry the contents of addresses 0..15 in order. Beat 5 carries address 4 (row 1, col 0), with R0 from bits [47:40].
- Start while busy: a second start in cycle 10 → timing identical to the basic frame; exactly 16 HSYNC beats, one ctrl_done.
- Back-to-back: start in cycle 31 is ignored. Start in cycle 32 → VSYNC in cycles 33-36, ctrl_done in cycle 63.
- Reset mid-frame: HRESET asserted in cycle 14 → all outputs 0 immediately, no ctrl_done. A new start gives the basic-frame timing relative to the new start.
- Default parameters: one frame → exactly 196608 HSYNC beats and final mem_addr=196607. Feeding the outputs into the BMP writer makes its Write_Done assert.

Source files
------------

// File: rtl/image_pair_streamer.sv
// rtl/image_pair_streamer.sv - RGB888 pixel-pair frame source with VSYNC/HSYNC timing
//
// Purpose: reads an image stored as 48-bit pixel pairs from a synchronous
// frame memory and streams it top row first, left to right. VSYNC is held
// during a start-up delay. Every row is preceded by HSYNC_DELAY blanking cycles.
// Each pixel pair is presented on DATA_* with HSYNC high, two cycles after
// its read strobe.
//
// Ports:
//   HCLK        clock, rising edge
//   HRESET      asynchronous active-high reset
//   start       one-cycle pulse, starts a frame when idle
//   mem_rd_en   frame memory read strobe
//   mem_addr    pair address = row*(WIDTH/2)+col
//   mem_rdata   {R0,G0,B0,R1,G1,B1}, valid the cycle after mem_rd_en
//   VSYNC       high during the start-up delay
//   HSYNC       qualifies DATA_* (one pixel pair per high cycle)
//   DATA_*0     even (left) pixel of the pair
//   DATA_*1     odd (right) pixel of the pair
//   busy        high in every non-idle state
//   ctrl_done   one-cycle frame-complete pulse
module image_pair_streamer #(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int START_UP_DELAY = 100,
   parameter int HSYNC_DELAY    = 160,
   parameter int ADDR_W         = 18
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [47:0]       mem_rdata,
   output logic              VSYNC,
   output logic              HSYNC,
   output logic [7:0]        DATA_R0,
   output logic [7:0]        DATA_G0,
   output logic [7:0]        DATA_B0,
   output logic [7:0]        DATA_R1,
   output logic [7:0]        DATA_G1,
   output logic [7:0]        DATA_B1,
   output logic              busy,
   output logic              ctrl_done
);

   localparam int PAIRS   = WIDTH / 2;
   localparam int DONE_LEN = 3;
   // The shared delay counter serves VSYNC, HSYNC and DONE, so it covers the longest.
   localparam int DLY_A   = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
   localparam int DLY_MAX = (DLY_A > DONE_LEN) ? DLY_A : DONE_LEN;
   localparam int CNT_W   = $clog2(DLY_MAX);
   localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int COL_W   = $clog2(PAIRS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_HSYNC,
      S_DATA,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic               r_rd_d1;
   logic               r_hsync;
   logic [47:0]        r_pix;

   logic               w_vs_end;
   logic               w_hs_end;
   logic               w_done_end;
   logic               w_row_end;
   logic               w_last_row;

   assign w_vs_end   = (r_cnt == CNT_W'(START_UP_DELAY - 1));
   assign w_hs_end   = (r_cnt == CNT_W'(HSYNC_DELAY - 1));
   assign w_done_end = (r_cnt == CNT_W'(DONE_LEN - 1));
   assign w_row_end  = (r_col == COL_W'(PAIRS - 1));
   assign w_last_row = (r_row == ROW_W'(HEIGHT - 1));

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_rd_en = 1'b0;
      VSYNC     = 1'b0;
      busy      = 1'b1;
      ctrl_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = S_VSYNC;
            end
         end
         S_VSYNC: begin
            VSYNC = 1'b1;
            if (w_vs_end) begin
               w_next = S_HSYNC;
            end
         end
         S_HSYNC: begin
            if (w_hs_end) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            mem_rd_en = 1'b1;
            if (w_row_end) begin
               w_next = w_last_row ? S_DONE : S_HSYNC;
            end
         end
         S_DONE: begin
            // The pulse lands after the last HSYNC beat has drained from the pipeline.
            if (w_done_end) begin
               ctrl_done = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Delay counter restarts on every state change so each phase counts from 0.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_cnt <= '0;
      end else if (w_next != r_state) begin
         r_cnt <= '0;
      end else if (r_state == S_VSYNC || r_state == S_HSYNC || r_state == S_DONE) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   // Row stays at HEIGHT-1 through the last row, then clears in DONE so the
   // address never points past the image once the frame ends.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_row <= '0;
         r_col <= '0;
      end else if (r_state == S_DATA) begin
         if (w_row_end) begin
            r_col <= '0;
            if (!w_last_row) begin
               r_row <= r_row + ROW_W'(1);
            end
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end else if (r_state == S_DONE || r_state == S_IDLE) begin
         r_row <= '0;
         r_col <= '0;
      end
   end

   assign mem_addr = ADDR_W'(r_row) * ADDR_W'(PAIRS) + ADDR_W'(r_col);

   // Fixed 2-cycle output pipeline: the read strobe is delayed one cycle to meet
   // the returning data, then captured together with it onto DATA_*/HSYNC.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_rd_d1 <= 1'b0;
         r_hsync <= 1'b0;
         r_pix   <= '0;
      end else begin
         r_rd_d1 <= mem_rd_en;
         r_hsync <= r_rd_d1;
         if (r_rd_d1) begin
            r_pix <= mem_rdata;
         end
      end
   end

   assign HSYNC   = r_hsync;
   assign DATA_R0 = r_pix[47:40];
   assign DATA_G0 = r_pix[39:32];
   assign DATA_B0 = r_pix[31:24];
   assign DATA_R1 = r_pix[23:16];
   assign DATA_G1 = r_pix[15:8];
   assign DATA_B1 = r_pix[7:0];

endmodule

// File: tb/tb_image_pair_streamer.sv
// tb/tb_image_pair_streamer.sv - scoreboard bench for image_pair_streamer
module tb_image_pair_streamer;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int SUD  = 4;
   localparam int HD   = 2;
   localparam int AW   = 4;
   localparam int HALF = W / 2;
   localparam int NP   = W * H / 2;
   localparam int RS   = HD + HALF;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [47:0]   mem_rdata = '0;
   logic          VSYNC, HSYNC, busy, ctrl_done;
   logic [7:0]    r0, g0, b0, r1, g1, b1;
   logic [47:0]   pix;

   logic [47:0]   mem [NP];

   typedef struct {
      int          c;
      logic [47:0] d;
   } beat_t;

   beat_t q[$];
   int    cyc = 0;
   int    tests = 0;
   int    fails = 0;
   int    fs = -1;
   int    epoch = 0;

   always #5 clk = ~clk;

   image_pair_streamer #(
      .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD), .ADDR_W(AW)
   ) dut (
      .HCLK(clk), .HRESET(rst), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .VSYNC(VSYNC), .HSYNC(HSYNC),
      .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
      .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
      .busy(busy), .ctrl_done(ctrl_done)
   );

   assign pix = {r0, g0, b0, r1, g1, b1};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference timing: frame accepted in cycle fs; VSYNC for SUD cycles, then
   // H rows of (HD blanking + HALF reads); output beats trail reads by 2 cycles.
   function automatic int done_cycle();
      return fs + SUD + H * RS + 3;
   endfunction

   function automatic bit exp_rd(int c);
      int k;
      if (fs < 0) return 1'b0;
      k = c - fs - SUD - 1;
      if (k < 0) return 1'b0;
      return (k / RS < H) && (k % RS >= HD);
   endfunction

   function automatic int exp_addr(int c);
      int k;
      k = c - fs - SUD - 1;
      return (k / RS) * HALF + (k % RS) - HD;
   endfunction

   function automatic bit exp_vs(int c);
      return (fs >= 0) && (c - fs >= 1) && (c - fs <= SUD);
   endfunction

   function automatic bit exp_busy(int c);
      return (fs >= 0) && (c - fs >= 1) && (c <= done_cycle());
   endfunction

   function automatic bit exp_done(int c);
      return (fs >= 0) && (c == done_cycle());
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic accept(input int c);
      beat_t b;
      fs = c;
      for (int a = 0; a < NP; a++) begin
         b.c = c + SUD + HD * (a / HALF + 1) + HALF * (a / HALF) + (a % HALF) + 3;
         b.d = mem[a];
         q.push_back(b);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      if (fs < 0 || cyc > done_cycle()) accept(cyc);
      step(1);
      start = 1'b0;
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_vsync"}, VSYNC, 0);
      chk({nm, "_hsync"}, HSYNC, 0);
      chk({nm, "_rd"}, mem_rd_en, 0);
      chk({nm, "_done"}, ctrl_done, 0);
      chk({nm, "_addr"}, mem_addr, 0);
      chk({nm, "_data"}, pix, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      epoch++;
      fs = -1;
      q.delete();
      #1;
      check_zero("reset");
      #1;
      rst = 1'b0;
      step(1);
   endtask

   // Monitor: per-cycle timing against the model, data beats against the scoreboard.
   initial begin
      int          my_epoch;
      logic [47:0] last;
      beat_t       b;
      my_epoch = 0;
      last = '0;
      forever begin
         @(negedge clk);
         if (my_epoch != epoch) begin
            my_epoch = epoch;
            last = '0;
         end
         chk("vsync", VSYNC, exp_vs(cyc));
         chk("busy", busy, exp_busy(cyc));
         chk("rd_en", mem_rd_en, exp_rd(cyc));
         chk("hsync", HSYNC, exp_rd(cyc - 2));
         chk("ctrl_done", ctrl_done, exp_done(cyc));
         if (mem_rd_en && exp_rd(cyc)) chk("mem_addr", mem_addr, exp_addr(cyc));
         if (HSYNC) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL beat_extra cycle=%0d actual=%0h expected=none", cyc, pix);
            end else begin
               b = q.pop_front();
               chk("beat_cycle", cyc, b.c);
               chk("beat_data", pix, b.d);
               last = b.d;
            end
         end else begin
            chk("data_hold", pix, last);
         end
      end
   end

   initial begin
      int s;
      int guard;
      for (int a = 0; a < NP; a++) mem[a] = {6{8'(a)}};
      #1;
      rst = 1'b1;
      #1;
      check_zero("por");
      step(2);
      rst = 1'b0;
      step(2);

      // Basic frame with an ignored start while busy, then the DONE-cycle and
      // first-idle-cycle starts.
      s = cyc;
      pulse_start();
      step(9);
      pulse_start();
      step(s + 31 - cyc);
      pulse_start();
      pulse_start();
      step(35);

      // Reset in the middle of a frame, then a fresh frame.
      s = cyc;
      pulse_start();
      step(s + 14 - cyc);
      do_reset();
      step(2);
      pulse_start();
      step(40);

      // Randomized frames: random contents, gaps, spurious starts and resets.
      for (int f = 0; f < 10; f++) begin
         for (int a = 0; a < NP; a++) mem[a] = {$urandom(), 16'($urandom())};
         step($urandom_range(0, 4));
         pulse_start();
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            step($urandom_range(1, 14));
            pulse_start();
         end
         if ($urandom_range(0, 3) == 0) begin
            step($urandom_range(1, 12));
            do_reset();
         end
         guard = 0;
         while (fs >= 0 && cyc <= done_cycle() + 1 && guard < 200) begin
            step(1);
            guard++;
         end
         chk("drain_bound", guard < 200, 1);
         step(1);
      end

      step(4);
      chk("scoreboard_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
